// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle RV-subset core (fetch/decode/exec/mem/wb) with handshaked external memories.
// Optional macro MC_CPU_ILLEGAL_HALT_EN: unsupported instructions halt the core instead of acting as NOPs.
module mc_cpu #(
   parameter int unsigned XLEN = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned PC_INC = 1,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  alu_result,
   output logic             alu_zero,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic             dmem_ready,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   state_t            r_state, w_next_state;
   logic [31:0]       r_ir;
   logic [XLEN-1:0]   r_pc, r_a, r_b, r_imm, r_alu, r_mdr;
   logic [XLEN-1:0]   r_regs [32];
   logic [CNT_W-1:0]  r_instret;

   logic [6:0]        w_opcode;
   logic [4:0]        w_rd, w_rs1, w_rs2;
   logic [2:0]        w_f3;
   logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm;
   logic [XLEN-1:0]   w_alu;
   logic              w_legal;
   logic              w_retire;
   logic              w_taken;

   assign w_opcode = r_ir[6:0];
   assign w_rd     = r_ir[11:7];
   assign w_f3     = r_ir[14:12];
   assign w_rs1    = r_ir[19:15];
   assign w_rs2    = r_ir[24:20];

   assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
   assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
   assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

   always_comb begin
      w_imm = w_imm_i;
      case (w_opcode)
         OP_ST:   w_imm = w_imm_s;
         OP_BR:   w_imm = w_imm_b;
         default: w_imm = w_imm_i;
      endcase
   end

   // ALU and legality decode for the instruction in IR
   always_comb begin
      w_alu   = r_a + r_imm;
      w_legal = 1'b1;
      case (w_opcode)
         OP_R: begin
            case (w_f3)
               3'b000:  w_alu = r_ir[30] ? (r_a - r_b) : (r_a + r_b);
               3'b111:  w_alu = r_a & r_b;
               3'b110:  w_alu = r_a | r_b;
               default: w_legal = 1'b0;
            endcase
         end
         OP_IMM:  w_legal = (w_f3 == 3'b000);
         OP_LD:   w_legal = 1'b1;
         OP_ST:   w_legal = 1'b1;
         OP_BR:   w_alu = r_a - r_b;
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH:  if (imem_ready) w_next_state = S_DECODE;
         S_DECODE: w_next_state = S_EXEC;
         S_EXEC: begin
            if (!w_legal) begin
`ifdef MC_CPU_ILLEGAL_HALT_EN
               w_next_state = S_HALT;
`else
               w_next_state = S_FETCH;
`endif
            end else begin
               case (w_opcode)
                  OP_LD, OP_ST: w_next_state = S_MEM;
                  OP_BR:        w_next_state = S_FETCH;
                  default:      w_next_state = S_WB;
               endcase
            end
         end
         S_MEM:    if (dmem_ready) w_next_state = (w_opcode == OP_LD) ? S_WB : S_FETCH;
         S_WB:     w_next_state = S_FETCH;
         S_HALT:   w_next_state = S_HALT;
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Every path back to FETCH (other than reset) retires one instruction
   assign w_retire = (r_state != S_FETCH) && (w_next_state == S_FETCH);
   assign w_taken  = (r_state == S_EXEC) && w_legal && (w_opcode == OP_BR) && (r_a == r_b);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_imm     <= '0;
         r_alu     <= '0;
         r_mdr     <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_FETCH && imem_ready) r_ir <= imem_rdata;
         if (r_state == S_DECODE) begin
            r_a   <= (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
            r_b   <= (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
            r_imm <= w_imm;
         end
         if (r_state == S_EXEC) r_alu <= w_alu;
         if (r_state == S_MEM && dmem_ready) r_mdr <= dmem_rdata;
         if (w_retire) begin
            r_pc      <= w_taken ? (r_pc + r_imm) : (r_pc + XLEN'(PC_INC));
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (r_state == S_WB && w_rd != 5'd0) begin
         r_regs[w_rd] <= (w_opcode == OP_LD) ? r_mdr : r_alu;
      end
   end

   assign pc         = r_pc;
   assign alu_result = r_alu;
   assign alu_zero   = (r_alu == '0);
   assign imem_req   = (r_state == S_FETCH);
   assign imem_addr  = r_pc;
   assign dmem_req   = (r_state == S_MEM);
   assign dmem_we    = (r_state == S_MEM) && (w_opcode == OP_ST);
   assign dmem_addr  = r_alu;
   assign dmem_wdata = r_b;
   assign instret    = r_instret;
`ifdef MC_CPU_ILLEGAL_HALT_EN
   assign halted     = (r_state == S_HALT);
`else
   assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: directed instruction sequence for mc_cpu; register contents are observed through stores.
module tb_mc_cpu;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc, alu_result, imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
   logic        alu_zero, imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
   logic [31:0] imem_rdata, instret;

   int          checks = 0;
   int          failures = 0;
   int          cyc, d_cnt, exp_ret, tot;
   logic [63:0] d_addr, d_wdata;
   logic        d_we, hung, both_seen;

   mc_cpu dut (
      .clk(clk), .reset(reset), .pc(pc), .alu_result(alu_result), .alu_zero(alu_zero),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halted(halted), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction, answer the data side after dwait stall cycles, run until FETCH again
   task automatic run(input logic [31:0] ins, input int dwait, input logic [63:0] rdata, input int budget);
      int wcnt;
      wcnt = 0; cyc = 0; d_cnt = 0; hung = 1'b0;
      imem_rdata = ins;
      imem_ready = 1'b1;
      do begin
         @(posedge clk); #1;
         cyc++;
         imem_ready = 1'b0;
         if (imem_req && dmem_req) both_seen = 1'b1;
         if (dmem_req) begin
            if (d_cnt == 0) begin
               d_addr = dmem_addr; d_wdata = dmem_wdata; d_we = dmem_we;
            end
            d_cnt++;
            dmem_ready = (wcnt == dwait);
            dmem_rdata = rdata;
            wcnt++;
         end else begin
            dmem_ready = 1'b0;
         end
      end while (!imem_req && cyc < budget);
      if (!imem_req) hung = 1'b1;
      dmem_ready = 1'b0;
   endtask

   task automatic step_ins(input string tag, input logic [31:0] ins, input int dwait,
                           input logic [63:0] rdata, input int exp_cyc, input logic [63:0] exp_pc);
      run(ins, dwait, rdata, 40);
      exp_ret++;
      chk({tag, ".done"}, 64'(hung), 64'd0);
      chk({tag, ".cycles"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, ".pc"}, pc, exp_pc);
      chk({tag, ".instret"}, 64'(instret), 64'(exp_ret));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      imem_ready = 1'b0; imem_rdata = '0;
      dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_ret = 0;
   endtask

   initial begin
      both_seen = 1'b0;
      do_reset();
      chk("rst.pc", pc, 64'd0);
      chk("rst.imem_addr", imem_addr, 64'd0);
      chk("rst.alu", alu_result, 64'd0);
      chk("rst.zero", 64'(alu_zero), 64'd1);
      chk("rst.imem_req", 64'(imem_req), 64'd1);
      chk("rst.dmem_req", 64'(dmem_req), 64'd0);
      chk("rst.dmem_we", 64'(dmem_we), 64'd0);
      chk("rst.halted", 64'(halted), 64'd0);
      chk("rst.instret", 64'(instret), 64'd0);

      // addi x1,x0,5 ; addi x2,x0,7 ; add x3,x1,x2
      step_ins("addi1", 32'h00500093, 0, 64'd0, 4, 64'd1);
      tot = cyc;
      chk("addi1.alu", alu_result, 64'd5);
      step_ins("addi2", 32'h00700113, 0, 64'd0, 4, 64'd2);
      tot += cyc;
      step_ins("add", 32'h002081B3, 0, 64'd0, 4, 64'd3);
      tot += cyc;
      chk("add.alu", alu_result, 64'd12);
      chk("add.total_cycles", 64'(tot), 64'd12);

      // addi x2,x0,5 ; sub x4,x1,x2
      step_ins("addi3", 32'h00500113, 0, 64'd0, 4, 64'd4);
      step_ins("sub", 32'h40208233, 0, 64'd0, 4, 64'd5);
      chk("sub.alu", alu_result, 64'd0);
      chk("sub.zero", 64'(alu_zero), 64'd1);

      // sd x3,8(x0) and ld x5,8(x0) with two stall cycles each
      step_ins("sd", 32'h00303423, 2, 64'd0, 6, 64'd6);
      chk("sd.addr", d_addr, 64'd8);
      chk("sd.wdata", d_wdata, 64'd12);
      chk("sd.we", 64'(d_we), 64'd1);
      chk("sd.req_cycles", 64'(d_cnt), 64'd3);
      step_ins("ld", 32'h00803283, 2, 64'd12, 7, 64'd7);
      chk("ld.addr", d_addr, 64'd8);
      chk("ld.we", 64'(d_we), 64'd0);
      step_ins("sd_x5", 32'h00503823, 0, 64'd0, 4, 64'd8);
      chk("sd_x5.addr", d_addr, 64'd16);
      chk("sd_x5.wdata", d_wdata, 64'd12);
      step_ins("sd_x4", 32'h00403023, 0, 64'd0, 4, 64'd9);
      chk("sd_x4.wdata", d_wdata, 64'd0);

      // beq taken +8, not taken, taken -4
      step_ins("beq_t", 32'h00000463, 0, 64'd0, 3, 64'd17);
      chk("beq_t.alu", alu_result, 64'd0);
      step_ins("beq_nt", 32'h00008463, 0, 64'd0, 3, 64'd18);
      chk("beq_nt.alu", alu_result, 64'd5);
      step_ins("beq_back", 32'hFE000EE3, 0, 64'd0, 3, 64'd14);

      // x0 stays zero; negative immediate; wraparound; and/or
      step_ins("addi_x0", 32'h00900013, 0, 64'd0, 4, 64'd15);
      chk("addi_x0.alu", alu_result, 64'd9);
      step_ins("sd_x0", 32'h00003023, 0, 64'd0, 4, 64'd16);
      chk("sd_x0.wdata", d_wdata, 64'd0);
      step_ins("addi_neg", 32'hFFF00313, 0, 64'd0, 4, 64'd17);
      chk("addi_neg.alu", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
      step_ins("sd_x6", 32'h00603023, 0, 64'd0, 4, 64'd18);
      chk("sd_x6.wdata", d_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
      step_ins("addi_wrap", 32'h00130393, 0, 64'd0, 4, 64'd19);
      chk("addi_wrap.alu", alu_result, 64'd0);
      chk("addi_wrap.zero", 64'(alu_zero), 64'd1);
      step_ins("and", 32'h0030F433, 0, 64'd0, 4, 64'd20);
      chk("and.alu", alu_result, 64'd4);
      step_ins("or", 32'h0030E4B3, 0, 64'd0, 4, 64'd21);
      chk("or.alu", alu_result, 64'd13);

      // unsupported opcode
`ifdef MC_CPU_ILLEGAL_HALT_EN
      run(32'h0000007F, 0, 64'd0, 13);
      chk("illegal.no_refetch", 64'(hung), 64'd1);
      chk("illegal.halted", 64'(halted), 64'd1);
      chk("illegal.pc", pc, 64'd21);
      chk("illegal.instret", 64'(instret), 64'd19);
      chk("illegal.imem_req", 64'(imem_req), 64'd0);
`else
      step_ins("illegal", 32'h0000007F, 0, 64'd0, 3, 64'd22);
      chk("illegal.halted", 64'(halted), 64'd0);
`endif
      chk("req_exclusive", 64'(both_seen), 64'd0);

      // reset in the middle of a stalled store
      do_reset();
      step_ins("r_addi", 32'h00500093, 0, 64'd0, 4, 64'd1);
      imem_rdata = 32'h00103023;
      imem_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         imem_ready = 1'b0;
      end
      chk("mid.dmem_req", 64'(dmem_req), 64'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("mid_rst.dmem_req", 64'(dmem_req), 64'd0);
      chk("mid_rst.pc", pc, 64'd0);
      chk("mid_rst.imem_req", 64'(imem_req), 64'd1);
      chk("mid_rst.instret", 64'(instret), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_ret = 0;
      step_ins("post_rst_sd", 32'h00103023, 0, 64'd0, 4, 64'd1);
      chk("post_rst_sd.wdata", d_wdata, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
